// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: reads both operands, holds them in an ID/EX register and
// tracks in-flight register writes in a scoreboard to stall on RAW hazards.
module operand_fetch_stage #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned NREG  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_instr,
  output logic             in_ready,
  output logic [3:0]       Read1,
  output logic [3:0]       Read2,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] Data2,
  input  logic             wb_en,
  input  logic [3:0]       wb_reg,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_opcode,
  output logic [3:0]       out_rd,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_imm,
  output logic             out_wr,
  output logic [NREG-1:0]  sb_pending
);

  logic [3:0] opcode, rd, rs, rt, imm;
  logic       writes_rd, uses_rs, uses_rt;
  logic [NREG-1:0] clr_mask, set_mask, pend;
  logic       hazard, ready, accept, issue;

  logic             valid_q, valid_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [3:0]       rd_q, rd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             wr_q, wr_d;
  logic [NREG-1:0]  sb_q, sb_d;

  assign opcode = in_instr[19:16];
  assign rd     = in_instr[15:12];
  assign rs     = in_instr[11:8];
  assign rt     = in_instr[7:4];
  assign imm    = in_instr[3:0];

  assign writes_rd = (opcode < 4'hC);
  assign uses_rs   = (opcode != 4'hF);
  assign uses_rt   = (opcode <= 4'h7) || (opcode == 4'hC) || (opcode == 4'hD);

  // A writeback this cycle is readable at the closing edge, so it no longer blocks.
  assign clr_mask = wb_en ? (NREG'(1) << wb_reg) : '0;
  assign pend     = sb_q & ~clr_mask;

  always_comb begin
    hazard = (uses_rs && pend[rs]) || (uses_rt && pend[rt]);
    if (valid_q && wr_q && ((uses_rs && rd_q == rs) || (uses_rt && rd_q == rt))) begin
      hazard = 1'b1;
    end
  end

  assign ready    = !hazard && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && ready;
  assign issue    = valid_q && out_ready && !flush;
  assign set_mask = (issue && wr_q) ? (NREG'(1) << rd_q) : '0;

  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    wr_d     = wr_q;
    // Set after clear so an issue and retire on the same register leaves it pending.
    sb_d     = (sb_q & ~clr_mask) | set_mask;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      opcode_d = opcode;
      rd_d     = rd;
      a_d      = Data1;
      b_d      = Data2;
      imm_d    = {{(WIDTH-4){imm[3]}}, imm};
      wr_d     = writes_rd;
    end else if (issue) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      wr_q     <= 1'b0;
      sb_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      wr_q     <= wr_d;
      sb_q     <= sb_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign in_ready   = reset_n && ready;
  assign Read1      = reset_n ? rs : 4'h0;
  assign Read2      = reset_n ? rt : 4'h0;
  assign out_valid  = valid_q;
  assign out_opcode = opcode_q;
  assign out_rd     = rd_q;
  assign out_a      = a_q;
  assign out_b      = b_q;
  assign out_imm    = imm_q;
  assign out_wr     = wr_q;
  assign sb_pending = sb_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: expected ID/EX contents are queued on accept
// and compared on issue; handshake and scoreboard state are tracked by a reference model.
module tb_operand_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_instr = '0;
  logic        in_ready;
  logic [3:0]  Read1, Read2;
  logic [19:0] Data1, Data2;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_reg = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_opcode, out_rd;
  logic [19:0] out_a, out_b, out_imm;
  logic        out_wr;
  logic [15:0] sb_pending;

  logic [19:0] regs [16];
  assign Data1 = regs[Read1];
  assign Data2 = regs[Read2];

  always #5 clock = ~clock;

  operand_fetch_stage dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .Read1     (Read1),
    .Read2     (Read2),
    .Data1     (Data1),
    .Data2     (Data2),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_opcode(out_opcode),
    .out_rd    (out_rd),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_imm   (out_imm),
    .out_wr    (out_wr),
    .sb_pending(sb_pending)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [19:0] a;
    logic [19:0] b;
    logic [19:0] imm;
    logic        wr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_sb = '0;
  logic        exp_valid = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt,
                                     input logic [3:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  // Called right after inputs are driven on the falling edge; returns on the next one.
  task automatic tick();
    exp_t        e, h;
    logic [3:0]  op, rs, rt;
    logic        urs, urt, hz, rdy, iss;
    logic [15:0] pend, setm, clrm;
    #1;
    op   = in_instr[19:16];
    rs   = in_instr[11:8];
    rt   = in_instr[7:4];
    urs  = (op != 4'hF);
    urt  = (op <= 4'h7) || (op == 4'hC) || (op == 4'hD);
    clrm = wb_en ? (16'h1 << wb_reg) : 16'h0;
    pend = exp_sb & ~clrm;
    hz   = (urs && pend[rs]) || (urt && pend[rt]);
    if (exp_valid && exp_q.size() > 0) begin
      h = exp_q[0];
      if (h.wr && ((urs && h.rd == rs) || (urt && h.rd == rt))) hz = 1'b1;
    end
    rdy = !hz && !flush && (!exp_valid || out_ready);
    check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    iss  = exp_valid && out_ready && !flush;
    setm = 16'h0;
    if (exp_valid && (flush || out_ready)) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (iss) begin
          check("out_opcode", {28'b0, out_opcode}, {28'b0, e.op});
          check("out_rd", {28'b0, out_rd}, {28'b0, e.rd});
          check("out_a", {12'b0, out_a}, {12'b0, e.a});
          check("out_b", {12'b0, out_b}, {12'b0, e.b});
          check("out_imm", {12'b0, out_imm}, {12'b0, e.imm});
          check("out_wr", {31'b0, out_wr}, {31'b0, e.wr});
          if (e.wr) setm = 16'h1 << e.rd;
        end
      end
    end
    if (in_valid && rdy) begin
      e.op  = op;
      e.rd  = in_instr[15:12];
      e.rs  = rs;
      e.rt  = rt;
      e.a   = regs[rs];
      e.b   = regs[rt];
      e.imm = {{16{in_instr[3]}}, in_instr[3:0]};
      e.wr  = (op < 4'hC);
      exp_q.push_back(e);
    end
    if (flush) exp_valid = 1'b0;
    else if (in_valid && rdy) exp_valid = 1'b1;
    else if (iss) exp_valid = 1'b0;
    exp_sb = (exp_sb & ~clrm) | setm;
    @(posedge clock);
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    check("sb_pending", {16'b0, sb_pending}, {16'b0, exp_sb});
    @(negedge clock);
  endtask

  task automatic ready_now(input string tag, input logic want);
    #1;
    check(tag, {31'b0, in_ready}, {31'b0, want});
  endtask

  task automatic wb(input logic en, input logic [3:0] r, input logic [19:0] v);
    wb_en  = en;
    wb_reg = r;
    if (en) regs[r] = v;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 20'(i * 32'h111);
    regs[2] = 20'd5;
    regs[3] = 20'd7;

    // Reset values with a valid instruction already presented.
    in_valid = 1'b1;
    in_instr = mk(4'h0, 4'h1, 4'h2, 4'h3, 4'hF);
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sb", {16'b0, sb_pending}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_a", {12'b0, out_a}, 32'd0);
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Basic fetch.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = mk(4'h0, 4'h1, 4'h2, 4'h3, 4'hF);
    tick();
    check("basic_a", {12'b0, out_a}, 32'd5);
    check("basic_b", {12'b0, out_b}, 32'd7);
    check("basic_imm", {12'b0, out_imm}, 32'hFFFFF);
    check("basic_wr", {31'b0, out_wr}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("basic_sb", {16'b0, sb_pending}, 32'h0002);

    // RAW stall on R1 until its writeback, accepting in that same cycle.
    in_valid = 1'b1;
    in_instr = mk(4'h1, 4'h5, 4'h1, 4'h0, 4'h2);
    ready_now("raw_stall", 1'b0);
    tick();
    tick();
    wb(1'b1, 4'h1, 20'h12345);
    ready_now("raw_release", 1'b1);
    tick();
    wb(1'b0, 4'h0, 20'h0);
    in_valid = 1'b0;
    check("raw_out_a", {12'b0, out_a}, 32'h12345);
    tick();
    check("raw_sb", {16'b0, sb_pending}, 32'h0020);
    wb(1'b1, 4'h5, 20'h00055);
    tick();
    wb(1'b0, 4'h0, 20'h0);

    // Holding-register hazard, then scoreboard hazard once the holder issues.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = mk(4'h0, 4'h4, 4'h2, 4'h3, 4'h1);
    tick();
    in_instr = mk(4'h0, 4'h7, 4'h2, 4'h4, 4'h0);
    ready_now("hold_hazard", 1'b0);
    tick();
    out_ready = 1'b1;
    ready_now("hold_hazard_ready", 1'b0);
    tick();
    ready_now("sb_hazard", 1'b0);
    tick();
    wb(1'b1, 4'h4, 20'h0ABCD);
    tick();
    wb(1'b0, 4'h0, 20'h0);
    in_valid = 1'b0;
    tick();
    wb(1'b1, 4'h7, 20'h00777);
    tick();
    wb(1'b0, 4'h0, 20'h0);

    // Issue and retire of R6 in the same cycle: set wins.
    in_valid = 1'b1;
    in_instr = mk(4'h0, 4'h6, 4'h2, 4'h3, 4'h7);
    tick();
    in_valid = 1'b0;
    wb(1'b1, 4'h6, 20'h00666);
    tick();
    check("setclr_sb6", {31'b0, sb_pending[6]}, 32'd1);
    tick();
    wb(1'b1, 4'hA, 20'h00AAA);
    tick();
    wb(1'b0, 4'h0, 20'h0);
    check("harmless_wb", {16'b0, sb_pending}, 32'h0000);

    // Flush together with out_ready: no issue, no accept.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = mk(4'h0, 4'h9, 4'h2, 4'h3, 4'h8);
    tick();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_instr  = mk(4'h0, 4'h8, 4'h2, 4'h3, 4'h0);
    ready_now("flush_ready", 1'b0);
    tick();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_sb9", {31'b0, sb_pending[9]}, 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();

    // Back-to-back stream including a NOP that names a pending register.
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) in_instr = mk(4'hF, 4'h0, 4'hA, 4'hB, 4'h3);
      else        in_instr = mk(4'(i), 4'(10 + i), 4'h2, 4'h3, 4'(i + 5));
      tick();
    end
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      wb(1'b1, 4'(10 + i), 20'(i));
      tick();
    end
    wb(1'b0, 4'h0, 20'h0);

    // Build out_valid=1 with sb_pending=0x0012, then reset asynchronously.
    in_valid = 1'b1;
    in_instr = mk(4'h0, 4'h1, 4'h2, 4'h3, 4'h0);
    tick();
    in_instr = mk(4'h0, 4'h4, 4'h2, 4'h3, 4'h0);
    tick();
    in_instr = mk(4'hE, 4'h0, 4'h2, 4'h3, 4'h0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("pre_rst_sb", {16'b0, sb_pending}, 32'h0012);
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_sb", {16'b0, sb_pending}, 32'd0);
    check("async_rst_opcode", {28'b0, out_opcode}, 32'd0);
    exp_q.delete();
    exp_valid = 1'b0;
    exp_sb    = '0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage of the 20-bit pipeline processor.
- Sits between the IF/ID register and EX.
- Drives the register file read addresses, captures both operands into an ID/EX holding register, and tracks in-flight register writes with a 16-entry scoreboard.
- Stalls upstream on RAW hazards and hands instructions to EX over a valid/ready handshake.

Parameters:
- WIDTH, 20, datapath and instruction width.
- NREG, 16, number of architectural registers; register address width is log2(NREG) = 4.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  IF/ID holds a valid instruction.
- in_instr  input  20  instruction: [19:16] opcode, [15:12] rd, [11:8] rs, [7:4] rt, [3:0] imm.
- in_ready  output  1  stage accepts in_instr this cycle.
- Read1  output  4  register file read address 1 = in_instr[11:8].
- Read2  output  4  register file read address 2 = in_instr[7:4].
- Data1  input  20  register file read data 1.
- Data2  input  20  register file read data 2.
- wb_en  input  1  writeback stage writes a register this cycle (RegWrite).
- wb_reg  input  4  register being written (WriteReg).
- flush  input  1  kill the held instruction and block acceptance this cycle.
- out_valid  output  1  ID/EX holding register is valid.
- out_ready  input  1  EX accepts this cycle.
- out_opcode  output  4  held opcode.
- out_rd  output  4  held destination register.
- out_a  output  20  held operand A.
- out_b  output  20  held operand B.
- out_imm  output  20  held immediate, sign-extended from imm[3:0].
- out_wr  output  1  held instruction writes rd.
- sb_pending  output  16  scoreboard state; bit i set means register i has an in-flight write.

Behaviour:
- Reset: all outputs held at zero while reset_n is low; out_valid = 0; sb_pending = 0; all holding fields = 0. Reset asserted mid-operation discards the held instruction and clears the scoreboard immediately.
- Decode rules, combinational from the opcode:
  - writes_rd = (opcode < 4'hC).
  - uses_rs = (opcode != 4'hF).
  - uses_rt = (opcode <= 4'h7) or opcode is 4'hC or 4'hD.
  - 4'hF is NOP.
- Pending set P = sb_pending with bit wb_reg cleared when wb_en is high. The register file writes on negedge, so a value written this cycle is readable at the closing posedge; no extra stall is needed for it.
- Hazard occurs when either condition holds:
  - (uses_rs and P[rs]) or (uses_rt and P[rt]).
  - out_valid and out_wr and (out_rd == rs with uses_rs, or out_rd == rt with uses_rt).
- in_ready = !hazard and !flush and (!out_valid or out_ready). It is combinational and does not depend on in_valid.
- Accept: in_valid and in_ready at posedge.
  - Capture opcode, rd, writes_rd, Data1, Data2, and the sign-extended imm.
  - Set out_valid = 1.
  - Latency is one cycle from accept to out_valid.
- Issue: out_valid and out_ready at posedge.
  - Set sb_pending[out_rd] if out_wr.
  - out_valid drops unless a new accept happens in the same cycle. Back-to-back throughput is one instruction per cycle.
- Retire: wb_en at posedge clears sb_pending[wb_reg].
- Issue set and retire clear on the same register in the same cycle: set wins.
- Writeback to a register with no pending bit is harmless; the bit stays 0.
- flush: at posedge, out_valid is cleared and no accept occurs. A flush coincident with out_ready does not issue, so no scoreboard bit is set. sb_pending is otherwise unaffected by flush; in-flight writes still retire.
- Holding fields keep their last values while out_valid = 0 or while stalled (out_valid and !out_ready).
- NOP accepted normally, with out_wr = 0 and no hazard check.
- All 16 registers, including register 0, are writable and tracked; there is no hardwired zero.

Test Plan:
- Reset: assert reset_n = 0 mid-stream with out_valid = 1 and sb_pending = 16'h0012 -> out_valid = 0 and sb_pending = 0 immediately, without waiting for a clock edge.
- Basic fetch: R2 = 5, R3 = 7; instr opcode 0, rd 1, rs 2, rt 3, imm 4'hF; out_ready = 1 -> next cycle out_a = 5, out_b = 7, out_imm = 20'hFFFFF, out_wr = 1; after issue sb_pending = 16'h0002.
- RAW stall: issue a write to R1, then present an instruction with rs = 1 -> in_ready = 0 until wb_en with wb_reg = 1. Accept occurs in that same cycle and out_a equals the written value.
- Holding-register hazard: out_valid = 1 with out_rd = 4 and out_ready = 0; incoming rt = 4 with opcode 0 -> in_ready = 0. Raise out_ready -> in_ready stays 0 because P[4] is now set.
- Simultaneous set/clear: issue a write to R6 while wb_en with wb_reg = 6 in the same cycle -> sb_pending[6] = 1 afterwards.
- Flush: out_valid = 1 with out_wr = 1 and rd = 9; flush together with out_ready -> out_valid = 0, sb_pending[9] = 0, and in_valid is ignored that cycle.
